rst_seq_multi: RTL

//  Parametrised power-on reset sequencer: NCH active-high reset domains, held after POR then released
//  in fixed order with a programmable stagger. Sits at the board top level between the raw reset
//  and the cores/peripherals (CPU, UART, USB, GPIO).

---
 rtl/rst_seq_pkg.sv | 28 ++
 rtl/rst_debounce.sv | 55 +++++
 rtl/rst_seq_multi.sv | 139 +++++++++++++
 3 files changed

// File: rtl/rst_seq_pkg.sv
// Shared definitions for the multi-domain reset sequencer: FSM states, reset cause codes
// and default parameter values.
package rst_seq_pkg;

   typedef enum logic [1:0] {
      ST_HOLD    = 2'd0,
      ST_RELEASE = 2'd1,
      ST_RUN     = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      CAUSE_POR  = 2'd0,
      CAUSE_SW   = 2'd1,
      CAUSE_EXT  = 2'd2,
      CAUSE_WDOG = 2'd3
   } cause_e;

   localparam int DEF_NCH         = 3;
   localparam int DEF_HOLD_CYC    = 256;
   localparam int DEF_STAGGER_CYC = 64;
   localparam int DEF_DEB_CYC     = 4096;
   localparam int DEF_WDOG_CYC    = 1 << 24;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/rst_debounce.sv
// Button reset conditioner: two-flop synchroniser plus stability counter. Emits a single-cycle
// request when the input has been stably low for DEB_CYC cycles; re-arms only after stable high.
module rst_debounce
   import rst_seq_pkg::*;
#(
   parameter int DEB_CYC = DEF_DEB_CYC
) (
   input  logic CLK,
   input  logic reset_n,
   input  logic btn_n_i,
   output logic req_o
);

   localparam int CW = $clog2(DEB_CYC + 1);

   logic          sync1_q, sync2_q;
   logic          stable_q, stable_d;
   logic          req_q, req_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      req_d    = 1'b0;
      if (sync2_q != stable_q) begin
         if (cnt_q == CW'(DEB_CYC - 1)) begin
            stable_d = sync2_q;
            req_d    = stable_q;  // only the high-to-low transition is a request
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments; the synchroniser resets to the idle-high level.
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q  <= 1'b1;
         sync2_q  <= 1'b1;
         stable_q <= 1'b1;
         cnt_q    <= '0;
         req_q    <= 1'b0;
      end else begin
         sync1_q  <= btn_n_i;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         req_q    <= req_d;
      end
   end

   assign req_o = req_q;

endmodule

// File: rtl/rst_seq_multi.sv
// Power-on reset sequencer: holds NCH reset domains after any trigger, then releases them in
// order with a fixed stagger. Define RST_WDOG_EN to add the watchdog trigger source.
module rst_seq_multi
   import rst_seq_pkg::*;
#(
   parameter int NCH         = DEF_NCH,
   parameter int HOLD_CYC    = DEF_HOLD_CYC,
   parameter int STAGGER_CYC = DEF_STAGGER_CYC,
   parameter int DEB_CYC     = DEF_DEB_CYC,
   parameter int WDOG_CYC    = DEF_WDOG_CYC
) (
   input  logic           CLK,
   input  logic           reset_n,
   input  logic           ext_rst_n,
   input  logic           sw_rst_req,
   input  logic           wdog_kick,
   output logic [NCH-1:0] rst_out,
   output logic           ready,
   output logic [1:0]     rst_cause
);

   localparam int CNT_W = $clog2(max2(HOLD_CYC, STAGGER_CYC) + 1);
   localparam int IDX_W = $clog2(NCH + 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [NCH-1:0]   rst_q, rst_d;
   logic             ready_q, ready_d;
   cause_e           cause_q, cause_d;
   logic             ext_req, wdog_fire, trig;

   rst_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
      .CLK     (CLK),
      .reset_n (reset_n),
      .btn_n_i (ext_rst_n),
      .req_o   (ext_req)
   );

`ifdef RST_WDOG_EN
   localparam int WD_W = $clog2(WDOG_CYC + 1);
   logic [WD_W-1:0] wd_q, wd_d;

   // The count only advances in RUN; a kick on the expiry edge suppresses the timeout.
   always_comb begin
      wd_d      = '0;
      wdog_fire = 1'b0;
      if (state_q == ST_RUN && !wdog_kick) begin
         if (wd_q == WD_W'(WDOG_CYC - 1)) wdog_fire = 1'b1;
         else                             wd_d      = wd_q + 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) wd_q <= '0;
      else          wd_q <= wd_d;
   end
`else
   logic unused_wdog;
   assign unused_wdog = wdog_kick | (WDOG_CYC < 2);
   assign wdog_fire   = 1'b0;
`endif

   assign trig = ext_req | wdog_fire | sw_rst_req;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      rst_d   = rst_q;
      ready_d = ready_q;
      cause_d = cause_q;
      if (trig) begin
         state_d = ST_HOLD;
         cnt_d   = '0;
         idx_d   = '0;
         rst_d   = '1;
         ready_d = 1'b0;
         cause_d = ext_req ? CAUSE_EXT : (wdog_fire ? CAUSE_WDOG : CAUSE_SW);
      end else begin
         case (state_q)
            ST_HOLD: begin
               if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
                  cnt_d    = '0;
                  rst_d[0] = 1'b0;
                  if (NCH == 1) begin
                     ready_d = 1'b1;
                     state_d = ST_RUN;
                  end else begin
                     idx_d   = IDX_W'(1);
                     state_d = ST_RELEASE;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_RELEASE: begin
               if (cnt_q == CNT_W'(STAGGER_CYC - 1)) begin
                  cnt_d = '0;
                  rst_d = rst_q & ~(NCH'(1) << idx_q);
                  idx_d = idx_q + 1'b1;
                  if (idx_q == IDX_W'(NCH - 1)) begin
                     ready_d = 1'b1;
                     state_d = ST_RUN;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_RUN: ;
            default: state_d = ST_HOLD;
         endcase
      end
   end

   // Outputs come straight from flops that reset_n sets asynchronously, so they cannot glitch low.
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_HOLD;
         cnt_q   <= '0;
         idx_q   <= '0;
         rst_q   <= '1;
         ready_q <= 1'b0;
         cause_q <= CAUSE_POR;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         rst_q   <= rst_d;
         ready_q <= ready_d;
         cause_q <= cause_d;
      end
   end

   assign rst_out   = rst_q;
   assign ready     = ready_q;
   assign rst_cause = cause_q;

endmodule
